// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: slot states, anode polarity, width helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg_pkg;

    // Slot phase: GUARD keeps every anode off, DRIVE lights the current digit.
    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } seg_state_e;

    // Common-anode display: a high level switches a digit off.
    localparam logic ANODE_OFF = 1'b1;

    // Ceiling log2, used to size counters and indices (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot counter running 0..REFRESH_DIV-1; flags describe the count the next edge loads.
// Latency: flags are combinational from the counter register.
// Backpressure: none, free-running.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_slot_start,   // next count is 0 (first cycle of a slot)
    output logic o_guard,        // next count lies in the guard interval
    output logic o_slot_last     // current count is the last one of the slot
);

    localparam int CW = (clog2(REFRESH_DIV) < 1) ? 1 : clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to 0 after the last count of a slot.
    always_comb begin
        o_slot_last = (cnt_q == CW'(REFRESH_DIV - 1));
        cnt_d       = o_slot_last ? '0 : cnt_q + CW'(1);
    end

    // Look-ahead flags let the parent register its outputs in step with the counter.
    always_comb begin
        o_slot_start = (cnt_d == '0);
        o_guard      = (cnt_d < CW'(GUARD_CYCLES));
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes an N-digit hex value onto a common-anode display, tear-free and with guard gaps.
// Latency: outputs registered; a load is shown from the next frame boundary onward.
// Backpressure: none; loads within one frame overwrite each other, the last one wins.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic                  i_blank_lz,
    output logic [3:0]            o_hex,
    output logic [N_DIGITS-1:0]   o_digit_en,
    output logic                  o_frame
);

    localparam int IW = (clog2(N_DIGITS) < 1) ? 1 : clog2(N_DIGITS);
    localparam int VW = 4 * N_DIGITS;

    logic                slot_start;
    logic                guard;
    logic                slot_last;
    logic                wrap;

    logic [IW-1:0]       idx_q,     idx_d;
    logic [VW-1:0]       shadow_q,  shadow_d;
    logic [VW-1:0]       active_q,  active_d;
    logic                pending_q, pending_d;
    logic [3:0]          hex_q,     hex_d;
    logic [N_DIGITS-1:0] en_q,      en_d;
    logic                frame_q,   frame_d;

    seg_state_e          state_d;
    logic [N_DIGITS-1:0] blank;
    logic                upper_nz;

    seg_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_slot_start (slot_start),
        .o_guard      (guard),
        .o_slot_last  (slot_last)
    );

    // Digit index advances at the end of each slot and wraps after the top digit.
    always_comb begin
        wrap  = slot_last && (idx_q == IW'(N_DIGITS - 1));
        idx_d = idx_q;
        if (slot_last) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end
    end

    // Double buffer: loads park in the shadow, active only changes at the frame wrap.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (i_load) begin
            shadow_d  = i_value;
            pending_d = 1'b1;
        end
        if (wrap) begin
            // A load on the wrap cycle bypasses the shadow so it is not delayed a frame.
            if (i_load) begin
                active_d = i_value;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end
    end

    // Leading-zero blanking: digit k>0 is dark when it and every digit above it are zero.
    always_comb begin
        blank    = '0;
        upper_nz = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            upper_nz = upper_nz | (active_d[4*k +: 4] != 4'h0);
            blank[k] = i_blank_lz & ~upper_nz;
        end
    end

    // Output next-state: nibble latched at slot start, anode lit only in DRIVE.
    always_comb begin
        state_d = guard ? GUARD : DRIVE;
        hex_d   = hex_q;
        if (slot_start) begin
            hex_d = active_d[4*idx_d +: 4];
        end
        en_d = {N_DIGITS{ANODE_OFF}};
        if ((state_d == DRIVE) && !blank[idx_d]) begin
            en_d[idx_d] = ~ANODE_OFF;
        end
        frame_d = slot_start && (idx_d == '0);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            hex_q     <= 4'h0;
            en_q      <= {N_DIGITS{ANODE_OFF}};
            frame_q   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            hex_q     <= hex_d;
            en_q      <= en_d;
            frame_q   <= frame_d;
        end
    end

    assign o_hex      = hex_q;
    assign o_digit_en = en_q;
    assign o_frame    = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
// Cycle numbers count clock edges since the last reset edge (cycle 0 shows reset state).
// Frame is 32 cycles: count = cyc%8, digit = (cyc/8)%4.
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  hex;
    logic [3:0]  digit_en;
    logic        frame;

    int n_assert;
    int n_fail;
    int cyc;

    seven_seg_scanner #(
        .N_DIGITS     (4),
        .REFRESH_DIV  (8),
        .GUARD_CYCLES (2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (load),
        .i_value    (value),
        .i_blank_lz (blank_lz),
        .o_hex      (hex),
        .o_digit_en (digit_en),
        .o_frame    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        blank_lz = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;

        // 1. reset state and slot timing
        chk("rst_en",    16'(digit_en), 16'hF);
        chk("rst_hex",   16'(hex),      16'h0);
        chk("rst_frame", 16'(frame),    16'h0);
        step();
        chk("guard1_en", 16'(digit_en), 16'hF);
        for (int c = 2; c < 8; c++) begin
            go_to(c);
            chk("drive0_en", 16'(digit_en), 16'hE);
        end
        go_to(8);  chk("guard_d1_a", 16'(digit_en), 16'hF);
        go_to(9);  chk("guard_d1_b", 16'(digit_en), 16'hF);
        go_to(10); chk("drive1_en",  16'(digit_en), 16'hD);
        go_to(31); chk("frame_low",  16'(frame),    16'h0);
        go_to(32); chk("frame_pulse", 16'(frame),   16'h1);
        go_to(33); chk("frame_1cyc", 16'(frame),    16'h0);

        // 2. load 1234 during digit-1 slot; old value until the wrap
        go_to(42); do_load(16'h1234);
        chk("old_d1",  16'(hex), 16'h0);
        go_to(56); chk("old_d3",  16'(hex), 16'h0);
        go_to(64); chk("new_d0",  16'(hex), 16'h4);
        chk("new_frame", 16'(frame), 16'h1);
        go_to(66); chk("new_d0_en", 16'(digit_en), 16'hE);
        go_to(72); chk("new_d1",  16'(hex), 16'h3);
        go_to(74); chk("new_d1_en", 16'(digit_en), 16'hD);
        go_to(80); chk("new_d2",  16'(hex), 16'h2);
        go_to(82); chk("new_d2_en", 16'(digit_en), 16'hB);
        go_to(88); chk("new_d3",  16'(hex), 16'h1);
        go_to(90); chk("new_d3_en", 16'(digit_en), 16'h7);

        // 3. 0050 with leading-zero blanking, then blanking off
        do_load(16'h0050);
        blank_lz = 1'b1;
        go_to(96);  chk("lz_d0_hex", 16'(hex), 16'h0);
        go_to(98);  chk("lz_d0_en",  16'(digit_en), 16'hE);
        go_to(104); chk("lz_d1_hex", 16'(hex), 16'h5);
        go_to(106); chk("lz_d1_en",  16'(digit_en), 16'hD);
        go_to(112); chk("lz_d2_hex", 16'(hex), 16'h0);
        go_to(114); chk("lz_d2_en",  16'(digit_en), 16'hF);
        go_to(122); chk("lz_d3_en",  16'(digit_en), 16'hF);
        blank_lz = 1'b0;
        step();     chk("lz_off_d3", 16'(digit_en), 16'h7);
        go_to(146); chk("lz_off_d2", 16'(digit_en), 16'hB);

        // 4. last load in a frame wins; load on the wrap cycle goes straight to active
        go_to(130); do_load(16'hAAAA);
        go_to(140); do_load(16'hBBBB);
        go_to(160); chk("win_d0", 16'(hex), 16'hB);
        go_to(162); chk("win_d0_en", 16'(digit_en), 16'hE);
        go_to(168); chk("win_d1", 16'(hex), 16'hB);
        go_to(184); chk("win_d3", 16'(hex), 16'hB);
        go_to(191); chk("pre_wrap", 16'(hex), 16'hB);
        do_load(16'hCCCC);
        chk("wrap_load_hex",   16'(hex),   16'hC);
        chk("wrap_load_frame", 16'(frame), 16'h1);

        // 5. reset during DRIVE with a load pending
        go_to(203); chk("pre_rst_en", 16'(digit_en), 16'hD);
        do_load(16'h9999);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        chk("mid_rst_en",    16'(digit_en), 16'hF);
        chk("mid_rst_hex",   16'(hex),      16'h0);
        chk("mid_rst_frame", 16'(frame),    16'h0);
        go_to(2);  chk("post_rst_en", 16'(digit_en), 16'hE);
        go_to(32); chk("lost_d0", 16'(hex), 16'h0);
        go_to(40); chk("lost_d1", 16'(hex), 16'h0);
        go_to(56); chk("lost_d3", 16'(hex), 16'h0);

        // 6. value 0 with blanking: only digit 0 lit
        blank_lz = 1'b1;
        go_to(58); chk("zero_d3_en", 16'(digit_en), 16'hF);
        go_to(64); chk("zero_d0_hex", 16'(hex), 16'h0);
        go_to(66); chk("zero_d0_en", 16'(digit_en), 16'hE);
        go_to(74); chk("zero_d1_en", 16'(digit_en), 16'hF);
        go_to(82); chk("zero_d2_en", 16'(digit_en), 16'hF);
        go_to(90); chk("zero_d3b_en", 16'(digit_en), 16'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
